monitor_dmem_access: RTL and testbench

MONITOR_DMEM_ACCESS -- requirements
Module: monitor_dmem_access

---
 rtl/monitor_pkg.sv | 15 +
 rtl/monitor_dmem_access_if.sv | 22 ++
 rtl/monitor_dmem_access.sv | 89 ++++++++
 tb/tb_monitor_dmem_access.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/monitor_pkg.sv
// monitor_pkg: register map, CMD/STATUS bit positions and FSM states shared by the dmem monitor.
package monitor_pkg;
    localparam logic [2:0] REG_ADDR   = 3'd0;
    localparam logic [2:0] REG_WDATA  = 3'd1;
    localparam logic [2:0] REG_CMD    = 3'd2;
    localparam logic [2:0] REG_STATUS = 3'd3;
    localparam logic [2:0] REG_RDATA  = 3'd4;
    localparam int CMD_RD     = 0;
    localparam int CMD_WR     = 1;
    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_TIMEOUT = 2;
    localparam int ST_REJECT  = 3;
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
endpackage

// File: rtl/monitor_dmem_access_if.sv
// monitor_dmem_access_if: Avalon slave registers plus the dmem request/ack side of the monitor.
interface monitor_dmem_access_if #(parameter int DW = 32);
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [DW-1:0] writedata;
    logic [DW-1:0] readdata;
    logic          mem_req;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    modport slave (
        input  address, chipselect, write_n, writedata, mem_rdata, mem_ack,
        output readdata, mem_req, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output address, chipselect, write_n, writedata, mem_rdata, mem_ack,
        input  readdata, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/monitor_dmem_access.sv
// monitor_dmem_access: Avalon-mapped monitor that reads/writes tinymips dmem while the core is halted.
// Define MONITOR_DMEM_AUTOINC_EN to post-increment ADDR by 4 after every acked access.
module monitor_dmem_access
    import monitor_pkg::*;
#(
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input logic clk,
    input logic reset_n,
    input logic cpu_halted,
    monitor_dmem_access_if.slave bus
);
`ifdef MONITOR_DMEM_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif
    state_t        state, state_n;
    logic [31:0]   addr_q;
    logic [DW-1:0] wdata_q, rdata_q;
    logic          we_q, done_q, timeout_q, reject_q;
    logic [15:0]   wait_cnt;
    logic          in_req, wr, cmd_wr, cmd_ok, start, reject, acked, expire;
    logic [3:0]    status;

    assign in_req = state == REQ;
    assign wr     = bus.chipselect && !bus.write_n;
    assign cmd_wr = wr && bus.address == REG_CMD;
    assign cmd_ok = !in_req && cpu_halted && (bus.writedata[CMD_RD] ^ bus.writedata[CMD_WR]);
    assign start  = cmd_wr && cmd_ok;
    assign reject = cmd_wr && !cmd_ok;
    assign acked  = in_req && bus.mem_ack;
    // the cycle that would bring the wait count up to TIMEOUT ends the access
    assign expire = in_req && !bus.mem_ack && wait_cnt == 16'(TIMEOUT - 1);

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_n;

    always_comb begin
        state_n = start ? REQ : acked ? DONE : (expire || state == DONE) ? IDLE : state;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            reject_q  <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            if (wr && !in_req && bus.address == REG_ADDR) addr_q <= 32'(bus.writedata);
            else if (acked && AUTOINC)                    addr_q <= addr_q + 32'd4;
            if (wr && !in_req && bus.address == REG_WDATA) wdata_q <= bus.writedata;
            if (start) begin
                done_q    <= 1'b0;
                timeout_q <= 1'b0;
                reject_q  <= 1'b0;
                we_q      <= bus.writedata[CMD_WR];
            end
            if (reject) reject_q <= 1'b1;
            if (acked) done_q <= 1'b1;
            if (acked && !we_q) rdata_q <= bus.mem_rdata;
            if (expire) timeout_q <= 1'b1;
            wait_cnt <= start ? '0 : (in_req && !bus.mem_ack) ? wait_cnt + 16'd1 : wait_cnt;
        end
    end

    always_comb begin
        status = '0;
        status[ST_BUSY]    = in_req;
        status[ST_DONE]    = done_q;
        status[ST_TIMEOUT] = timeout_q;
        status[ST_REJECT]  = reject_q;
        bus.readdata = bus.address == REG_ADDR   ? DW'(addr_q) :
                       bus.address == REG_WDATA  ? wdata_q :
                       bus.address == REG_STATUS ? DW'(status) :
                       bus.address == REG_RDATA  ? rdata_q : '0;
    end

    assign bus.mem_req   = in_req;
    assign bus.mem_we    = in_req && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_monitor_dmem_access.sv
// tb_monitor_dmem_access: directed checks of the dmem monitor (TIMEOUT=8); honours MONITOR_DMEM_AUTOINC_EN.
module tb_monitor_dmem_access;
    import monitor_pkg::*;
    localparam int DW = 32;
`ifdef MONITOR_DMEM_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic cpu_halted = 1'b0;
    int n_checks = 0;
    int n_fail = 0;
    int hi;
    logic [31:0] addr_exp;

    monitor_dmem_access_if #(.DW(DW)) bus ();
    monitor_dmem_access #(.DW(DW), .TIMEOUT(8)) dut (
        .clk(clk), .reset_n(reset_n), .cpu_halted(cpu_halted), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        bus.address = a;
        bus.writedata = d;
        bus.chipselect = 1'b1;
        bus.write_n = 1'b0;
        step();
        bus.chipselect = 1'b0;
        bus.write_n = 1'b1;
    endtask

    task automatic check_reg(input string tag, input logic [2:0] a, input logic [31:0] exp);
        bus.address = a;
        bus.chipselect = 1'b1;
        bus.write_n = 1'b1;
        #1;
        check(tag, bus.readdata, exp);
        bus.chipselect = 1'b0;
    endtask

    // counts mem_req-high cycles while acking in the n-th cycle
    task automatic ack_after(input int n, input logic [31:0] d, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            if (bus.mem_req) cnt++;
            if (i == n - 1) begin
                bus.mem_ack = 1'b1;
                bus.mem_rdata = d;
            end
            step();
            bus.mem_ack = 1'b0;
        end
    endtask

    initial begin
        bus.address = '0;
        bus.chipselect = 1'b0;
        bus.write_n = 1'b1;
        bus.writedata = '0;
        bus.mem_rdata = '0;
        bus.mem_ack = 1'b0;
        #1;
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check_reg("rst_status", REG_STATUS, 0);
        check_reg("rst_addr", REG_ADDR, 0);
        repeat (2) step();
        reset_n = 1'b1;
        cpu_halted = 1'b1;
        step();

        wr_reg(REG_ADDR, 32'h10);
        check_reg("addr_rb", REG_ADDR, 32'h10);
        wr_reg(REG_CMD, 32'h1);
        check("rd_req_next", bus.mem_req, 1);
        check("rd_mem_addr", bus.mem_addr, 32'h10);
        check("rd_mem_we", bus.mem_we, 0);
        check_reg("rd_busy", REG_STATUS, 32'h1);
        ack_after(3, 32'hDEADBEEF, hi);
        check("rd_req_cycles", hi, 3);
        check("rd_req_low", bus.mem_req, 0);
        check_reg("rd_status", REG_STATUS, 32'h2);
        check_reg("rd_rdata", REG_RDATA, 32'hDEADBEEF);
        step();
        check_reg("rd_status_idle", REG_STATUS, 32'h2);
        check_reg("rd_addr_after", REG_ADDR, AUTOINC ? 32'h14 : 32'h10);

        wr_reg(REG_ADDR, 32'h20);
        wr_reg(REG_WDATA, 32'h12345678);
        check_reg("wdata_rb", REG_WDATA, 32'h12345678);
        wr_reg(REG_CMD, 32'h2);
        check("wr_mem_we", bus.mem_we, 1);
        check("wr_mem_addr", bus.mem_addr, 32'h20);
        check("wr_mem_wdata", bus.mem_wdata, 32'h12345678);
        wr_reg(REG_ADDR, 32'h99);
        wr_reg(REG_WDATA, 32'h0);
        check("wr_addr_stable", bus.mem_addr, 32'h20);
        check("wr_wdata_stable", bus.mem_wdata, 32'h12345678);
        check("wr_we_stable", bus.mem_we, 1);
        ack_after(1, 32'hCAFEF00D, hi);
        check("wr_req_cycles", hi, 1);
        check_reg("wr_status", REG_STATUS, 32'h2);
        check_reg("wr_rdata_kept", REG_RDATA, 32'hDEADBEEF);
        check("wr_we_low", bus.mem_we, 0);
        addr_exp = AUTOINC ? 32'h24 : 32'h20;
        check_reg("wr_addr_after", REG_ADDR, addr_exp);
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'hBAD0BAD0;
        step();
        bus.mem_ack = 1'b0;
        step();
        check("stray_ack_req", bus.mem_req, 0);
        check_reg("stray_ack_rdata", REG_RDATA, 32'hDEADBEEF);
        check_reg("stray_ack_status", REG_STATUS, 32'h2);

        bus.mem_rdata = 32'h55;
        wr_reg(REG_CMD, 32'h1);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (!bus.mem_req) break;
            hi++;
            if (i == 2) cpu_halted = 1'b0;
            step();
        end
        cpu_halted = 1'b1;
        check("to_req_cycles", hi, 8);
        check_reg("to_status", REG_STATUS, 32'h4);
        check_reg("to_rdata_kept", REG_RDATA, 32'hDEADBEEF);
        check_reg("to_addr_kept", REG_ADDR, addr_exp);

        wr_reg(REG_CMD, 32'h3);
        check("rej_both_req", bus.mem_req, 0);
        check_reg("rej_both_status", REG_STATUS, 32'hC);
        check_reg("rej_addr_kept", REG_ADDR, addr_exp);
        wr_reg(REG_CMD, 32'h1);
        ack_after(1, 32'h11111111, hi);
        check_reg("rej_clear_status", REG_STATUS, 32'h2);
        cpu_halted = 1'b0;
        wr_reg(REG_CMD, 32'h1);
        check("rej_run_req", bus.mem_req, 0);
        check_reg("rej_run_status", REG_STATUS, 32'hA);
        cpu_halted = 1'b1;
        wr_reg(REG_CMD, 32'h1);
        ack_after(1, 32'h33333333, hi);
        wr_reg(REG_CMD, 32'h0);
        check("rej_none_req", bus.mem_req, 0);
        check_reg("rej_none_status", REG_STATUS, 32'hA);
        wr_reg(REG_CMD, 32'h1);
        wr_reg(REG_CMD, 32'h2);
        check_reg("rej_busy_status", REG_STATUS, 32'h9);
        check("rej_busy_req", bus.mem_req, 1);
        check("rej_busy_we", bus.mem_we, 0);
        ack_after(1, 32'h22222222, hi);
        check_reg("rej_busy_rdata", REG_RDATA, 32'h22222222);
        check_reg("rej_busy_done", REG_STATUS, 32'hA);
        step();
        check("rej_busy_no_req", bus.mem_req, 0);

        wr_reg(REG_ADDR, 32'h40);
        wr_reg(REG_CMD, 32'h1);
        check("rst_mid_req_on", bus.mem_req, 1);
        reset_n = 1'b0;
        #1;
        check("rst_mid_req_off", bus.mem_req, 0);
        check("rst_mid_mem_addr", bus.mem_addr, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step();
        check_reg("rst_rel_status", REG_STATUS, 0);
        check_reg("rst_rel_addr", REG_ADDR, 0);
        check_reg("rst_rel_rdata", REG_RDATA, 0);
        check("rst_rel_req", bus.mem_req, 0);

        wr_reg(REG_ADDR, 32'hFFFFFFFC);
        wr_reg(REG_CMD, 32'h1);
        check("ai_mem_addr1", bus.mem_addr, 32'hFFFFFFFC);
        ack_after(2, 32'hA5A5A5A5, hi);
        check_reg("ai_addr1", REG_ADDR, AUTOINC ? 32'h0 : 32'hFFFFFFFC);
        step();
        wr_reg(REG_CMD, 32'h1);
        check("ai_mem_addr2", bus.mem_addr, AUTOINC ? 32'h0 : 32'hFFFFFFFC);
        ack_after(1, 32'h5A5A5A5A, hi);
        check_reg("ai_addr2", REG_ADDR, AUTOINC ? 32'h4 : 32'hFFFFFFFC);
        check_reg("ai_rdata", REG_RDATA, 32'h5A5A5A5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
